// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter / fetch sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } pc_state_t;

  localparam int PC_W_DEF       = 10;
  localparam int PROG_LEN_DEF   = 1024;
  localparam int START_ADDR_DEF = 0;
  localparam int CNT_W_DEF      = 16;

  function automatic logic signed [31:0] sext8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

endpackage

// File: rtl/pc_ctrl_next_pc_calc.sv
// Combinational next-PC selection (JumpAbs > BranchEn > PC+1) with range check.
module next_pc_calc
  import pc_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int PROG_LEN = PROG_LEN_DEF
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [7:0]      target_i,
  input  logic            jump_abs_i,
  input  logic            branch_en_i,
  output logic [PC_W-1:0] next_pc_o,
  output logic            out_of_range_o
);

  localparam logic [PC_W+1:0] LIMIT = (PC_W+2)'(PROG_LEN);

  logic [PC_W+1:0] pc_ext_s;
  logic [PC_W+1:0] ofs_ext_s;
  logic [PC_W+1:0] abs_ext_s;
  logic [PC_W+1:0] cand_s;

  assign pc_ext_s  = {2'b00, pc_i};
  assign ofs_ext_s = (PC_W+2)'(sext8(target_i));
  assign abs_ext_s = (PC_W+2)'(target_i);

  // Candidate is kept two bits wider so a negative branch result shows up in the MSB.
  always_comb begin
    cand_s = pc_ext_s + (PC_W+2)'(1);
    if (jump_abs_i) begin
      cand_s = abs_ext_s;
    end else if (branch_en_i) begin
      cand_s = pc_ext_s + ofs_ext_s;
    end else begin
      cand_s = pc_ext_s + (PC_W+2)'(1);
    end
  end

  assign next_pc_o      = cand_s[PC_W-1:0];
  assign out_of_range_o = cand_s[PC_W+1] | (cand_s >= LIMIT);

endmodule

// File: rtl/pc_ctrl.sv
// Program counter and fetch sequencer: run/halt/fault FSM, PC register, cycle counter.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int PROG_LEN   = PROG_LEN_DEF,
  parameter int START_ADDR = START_ADDR_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             Stall,
  input  logic             BranchEn,
  input  logic             JumpAbs,
  input  logic [7:0]       Target,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic             Fault,
  output logic [CNT_W-1:0] CycleCnt
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  pc_state_t        state_q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             running_q;
  logic             done_q;
  logic             fault_q;
  logic [PC_W-1:0]  next_pc_s;
  logic             oor_s;

  next_pc_calc #(
    .PC_W     (PC_W),
    .PROG_LEN (PROG_LEN)
  ) u_next_pc (
    .pc_i           (pc_q),
    .target_i       (Target),
    .jump_abs_i     (JumpAbs),
    .branch_en_i    (BranchEn),
    .next_pc_o      (next_pc_s),
    .out_of_range_o (oor_s)
  );

  // FSM, PC register, saturating cycle counter and registered status flags.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      pc_q      <= START_PC;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HALTED, FAULT: begin
          if (Start) begin
            state_q   <= RUN;
            pc_q      <= START_PC;
            cnt_q     <= '0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          // The PC is left on the halting or offending instruction.
          if (Halt) begin
            state_q   <= HALTED;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (Stall) begin
            pc_q <= pc_q;
          end else if (oor_s) begin
            state_q   <= FAULT;
            running_q <= 1'b0;
            fault_q   <= 1'b1;
          end else begin
            pc_q <= next_pc_s;
          end
        end
        default: begin
          state_q   <= IDLE;
          pc_q      <= START_PC;
          cnt_q     <= '0;
          running_q <= 1'b0;
          done_q    <= 1'b0;
          fault_q   <= 1'b0;
        end
      endcase
    end
  end

  assign PC       = pc_q;
  assign CycleCnt = cnt_q;
  assign Running  = running_q;
  assign Done     = done_q;
  assign Fault    = fault_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl.
module tb_pc_ctrl;

  localparam int PC_W  = 10;
  localparam int CNT_W = 6;

  logic             CLK = 1'b0;
  logic             Reset = 1'b0;
  logic             Start = 1'b0;
  logic             Halt = 1'b0;
  logic             Stall = 1'b0;
  logic             BranchEn = 1'b0;
  logic             JumpAbs = 1'b0;
  logic [7:0]       Target = 8'd0;
  logic [PC_W-1:0]  PC;
  logic             Running;
  logic             Done;
  logic             Fault;
  logic [CNT_W-1:0] CycleCnt;

  int n_checks = 0;
  int n_fail   = 0;

  pc_ctrl #(
    .PC_W       (PC_W),
    .PROG_LEN   (1024),
    .START_ADDR (0),
    .CNT_W      (CNT_W)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Start    (Start),
    .Halt     (Halt),
    .Stall    (Stall),
    .BranchEn (BranchEn),
    .JumpAbs  (JumpAbs),
    .Target   (Target),
    .PC       (PC),
    .Running  (Running),
    .Done     (Done),
    .Fault    (Fault),
    .CycleCnt (CycleCnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input int exp_pc, input logic r, input logic d,
                        input logic f);
    chk({tag, "_pc"}, 32'(PC), exp_pc);
    chk({tag, "_flags(run,done,fault)"}, {29'd0, Running, Done, Fault}, {29'd0, r, d, f});
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic st, input logic h, input logic sl, input logic b,
                       input logic j, input logic [7:0] t);
    Start = st; Halt = h; Stall = sl; BranchEn = b; JumpAbs = j; Target = t;
  endtask

  initial begin
    // Reset state
    step();
    chk_st("reset", 0, 1'b0, 1'b0, 1'b0);
    chk("reset_cnt", 32'(CycleCnt), 32'd0);
    Reset = 1'b1;

    // Start, then free-running increments
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step();
    chk_st("start", 0, 1'b1, 1'b0, 1'b0);
    chk("start_cnt", 32'(CycleCnt), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("seq_pc", 32'(PC), i);
    end
    chk("seq_cnt", 32'(CycleCnt), 32'd5);
    chk("seq_running", 32'(Running), 32'd1);

    // Relative branches
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd20);
    step();
    chk("jmp20", 32'(PC), 32'd20);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF5);
    step();
    chk("br_m11", 32'(PC), 32'd9);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd6);
    step();
    chk("br_p6", 32'(PC), 32'd15);

    // JumpAbs wins over BranchEn, Stall wins over JumpAbs
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5);
    step();
    chk("jmp5", 32'(PC), 32'd5);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd39);
    step();
    chk("jab39", 32'(PC), 32'd39);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd80);
    step();
    chk_st("stall", 39, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step();
    chk("start_in_run", 32'(PC), 32'd40);
    chk("start_in_run_cnt", 32'(CycleCnt), 32'd12);

    // Negative branch out of range
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd12);
    step();
    chk("jmp12", 32'(PC), 32'd12);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE1);
    step();
    chk_st("fault_neg", 12, 1'b0, 1'b0, 1'b1);
    chk("fault_cnt", 32'(CycleCnt), 32'd14);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3);
    step();
    chk_st("fault_hold", 12, 1'b0, 1'b0, 1'b1);
    chk("fault_hold_cnt", 32'(CycleCnt), 32'd14);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step();
    chk_st("fault_restart", 0, 1'b1, 1'b0, 1'b0);
    chk("fault_restart_cnt", 32'(CycleCnt), 32'd0);

    // Halt beats Stall
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd50);
    step();
    chk("jmp50", 32'(PC), 32'd50);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    step();
    chk_st("halt", 50, 1'b0, 1'b1, 1'b0);
    chk("halt_cnt", 32'(CycleCnt), 32'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7);
    step(3);
    chk_st("halt_hold", 50, 1'b0, 1'b1, 1'b0);
    chk("halt_hold_cnt", 32'(CycleCnt), 32'd2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step();
    chk_st("halt_restart", 0, 1'b1, 1'b0, 1'b0);

    // Climb to the last legal PC, then fall off the end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd255);
    step();
    chk("jmp255", 32'(PC), 32'd255);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h7F);
    step(6);
    chk("br127x6", 32'(PC), 32'd1017);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd6);
    step();
    chk_st("pc_last", 1023, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step();
    chk_st("fault_end", 1023, 1'b0, 1'b0, 1'b1);

    // Cycle counter saturation
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(70);
    chk("sat_pc", 32'(PC), 32'd70);
    chk("sat_cnt", 32'(CycleCnt), 32'd63);

    // Asynchronous reset mid-cycle
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd37);
    step();
    chk("jmp37", 32'(PC), 32'd37);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd10);
    #2;
    Reset = 1'b0;
    #1;
    chk_st("async_rst", 0, 1'b0, 1'b0, 1'b0);
    chk("async_rst_cnt", 32'(CycleCnt), 32'd0);
    step();
    Reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(2);
    chk_st("idle_after_rst", 0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
